// File: rtl/jhash_pack.sv
// jhash_pack: output packer behind the jhash engine.
//
// Captures 32-bit hash results on hash_done, pairs consecutive results into
// 64-bit words ({second, first}) and queues them for the downstream 64-bit
// FIFO. An end-of-message marker (m_endn low) closes the current word; a
// half-filled word is flushed with PAD in the high half. Every word that
// closes a message is tagged last.
//
// Ports:
//   clk, rst     single rising-edge clock, asynchronous active-high reset
//   ce           clock enable; low holds all state and suppresses fo_wr
//   hash_out     hash result, qualified by hash_done
//   hash_done    one-cycle strobe for hash_out
//   m_endn       active-low end-of-message marker, sampled with hash_done
//   fo, fo_last  queue head word and its last tag (combinational)
//   fo_wr        write strobe into the downstream FIFO
//   fo_full      downstream FIFO full
//   pack_ovf     sticky: a completed word was dropped on a full queue
//   pack_empty   queue empty and no half word pending
//   hash_cnt     accepted-hash counter
//
// Build option: define JHASH_PACK_CNT_EN to build the 16-bit hash_cnt
// counter; otherwise hash_cnt is tied to zero.
//
// state | meaning
// ------+----------------------------------------------
// LO    | half register empty, next hash starts a word
// HI    | low half held, next hash completes the word

module jhash_pack #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] PAD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] hash_out,
  input  logic        hash_done,
  input  logic        m_endn,
  output logic [63:0] fo,
  output logic        fo_last,
  output logic        fo_wr,
  input  logic        fo_full,
  output logic        pack_ovf,
  output logic        pack_empty,
  output logic [15:0] hash_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {LO, HI} state_t;

  state_t      state, state_nxt;
  logic [31:0] lo_half, lo_half_nxt;

  logic [63:0] q_word [DEPTH];
  logic        q_last [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   q_cnt;

  logic        accept;
  logic        push;
  logic [63:0] push_word;
  logic        push_last;
  logic        pop;
  logic        q_empty, q_full;
  logic        push_ok;

  assign accept  = ce & hash_done;
  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == FULL_CNT);
  assign pop     = ce & ~q_empty & ~fo_full;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign push_ok = push & (~q_full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LO;
      lo_half <= '0;
    end else begin
      state   <= state_nxt;
      lo_half <= lo_half_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lo_half_nxt = lo_half;
    push        = 1'b0;
    push_word   = '0;
    push_last   = 1'b0;
    case (state)
      LO: begin
        if (accept) begin
          if (m_endn) begin
            lo_half_nxt = hash_out;
            state_nxt   = HI;
          end else begin
            push      = 1'b1;
            push_word = {PAD, hash_out};
            push_last = 1'b1;
          end
        end
      end
      HI: begin
        if (accept) begin
          push      = 1'b1;
          push_word = {hash_out, lo_half};
          push_last = ~m_endn;
          state_nxt = LO;
        end
      end
      default: state_nxt = LO;
    endcase
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_word[i] <= '0;
        q_last[i] <= 1'b0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_cnt    <= '0;
      pack_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        q_word[wr_ptr] <= push_word;
        q_last[wr_ptr] <= push_last;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
      if (push & ~push_ok)
        pack_ovf <= 1'b1;
    end
  end

  assign fo         = q_word[rd_ptr];
  assign fo_last    = q_last[rd_ptr];
  assign fo_wr      = pop;
  assign pack_empty = q_empty & (state == LO);

`ifdef JHASH_PACK_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (accept)
      cnt_q <= cnt_q + 16'd1;
  end

  assign hash_cnt = cnt_q;
`else
  assign hash_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_jhash_pack.sv
// Self-checking bench for jhash_pack: directed scenarios plus a randomized
// run, all checked against a word-level queue model of the packer.

module tb_jhash_pack;

  localparam int          DEPTH = 4;
  localparam logic [31:0] PAD   = 32'h0000_0000;
`ifdef JHASH_PACK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] hash_out;
  logic        hash_done;
  logic        m_endn;
  logic [63:0] fo;
  logic        fo_last;
  logic        fo_wr;
  logic        fo_full;
  logic        pack_ovf;
  logic        pack_empty;
  logic [15:0] hash_cnt;

  jhash_pack #(.DEPTH(DEPTH), .PAD(PAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .hash_out   (hash_out),
    .hash_done  (hash_done),
    .m_endn     (m_endn),
    .fo         (fo),
    .fo_last    (fo_last),
    .fo_wr      (fo_wr),
    .fo_full    (fo_full),
    .pack_ovf   (pack_ovf),
    .pack_empty (pack_empty),
    .hash_cnt   (hash_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: words waiting downstream, pending low half, flags.
  logic [64:0] mq[$];
  logic        m_half_v;
  logic [31:0] m_half;
  logic        m_ovf;
  logic [15:0] m_cnt;

  // Words seen leaving the DUT and words the model says should leave.
  logic [64:0] obs_q[$];
  logic [64:0] exp_q[$];

  // Values sampled during the most recent step.
  logic        s_wr;
  logic [63:0] s_fo;
  logic        s_last;
  logic        s_mpop;

  function automatic logic [15:0] exp_cnt();
    return CNT_EN ? m_cnt : 16'h0000;
  endfunction

  task automatic model_clear();
    mq.delete();
    obs_q.delete();
    exp_q.delete();
    m_half_v = 1'b0;
    m_half   = '0;
    m_ovf    = 1'b0;
    m_cnt    = '0;
  endtask

  // One clock cycle: drive inputs, sample outputs, advance the model.
  task automatic step(input bit c, input bit d, input logic [31:0] h,
                      input bit e, input bit f);
    logic [64:0] w;
    bit          push;
    int          sz;
    @(negedge clk);
    ce = c; hash_done = d; hash_out = h; m_endn = e; fo_full = f;
    #1;
    s_wr   = fo_wr;
    s_fo   = fo;
    s_last = fo_last;
    s_mpop = c && (mq.size() > 0) && !f;
    if (s_wr)   obs_q.push_back({s_last, s_fo});
    if (s_mpop) exp_q.push_back(mq[0]);
    push = 1'b0;
    w    = '0;
    if (c && d) begin
      m_cnt = m_cnt + 16'd1;
      if (!m_half_v) begin
        if (e) begin
          m_half   = h;
          m_half_v = 1'b1;
        end else begin
          w    = {1'b1, PAD, h};
          push = 1'b1;
        end
      end else begin
        w        = {!e, h, m_half};
        push     = 1'b1;
        m_half_v = 1'b0;
      end
    end
    sz = mq.size();
    if (s_mpop) void'(mq.pop_front());
    if (push) begin
      if (sz < DEPTH || s_mpop) mq.push_back(w);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce = 1'b0; hash_done = 1'b0; hash_out = '0; m_endn = 1'b1; fo_full = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step(1, 1, 32'hDEAD_0001, 1, 1);
    step(1, 1, 32'hDEAD_0002, 1, 1);
    step(1, 1, 32'hDEAD_0003, 1, 1);
    // Assert reset between edges: outputs must clear with no clock edge.
    rst = 1'b1;
    ce = 1'b0; hash_done = 1'b0; fo_full = 1'b0;
    #1;
    checks++; if (fo_wr !== 1'b0) begin errors++; $display("FAIL reset_fo_wr: got %b want 0", fo_wr); end
    checks++; if (fo !== 64'h0) begin errors++; $display("FAIL reset_fo: got %h want 0", fo); end
    checks++; if (fo_last !== 1'b0) begin errors++; $display("FAIL reset_fo_last: got %b want 0", fo_last); end
    checks++; if (pack_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", pack_ovf); end
    checks++; if (pack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", pack_empty); end
    checks++; if (hash_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", hash_cnt); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pair();
    do_reset();
    step(1, 1, 32'h1111_1111, 1, 0);
    step(1, 1, 32'h2222_2222, 1, 0);
    step(1, 0, 32'h0, 1, 0);
    checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL pair_wr: got %b want 1", s_wr); end
    checks++; if (s_fo !== 64'h2222_2222_1111_1111) begin errors++; $display("FAIL pair_fo: got %h want 2222222211111111", s_fo); end
    checks++; if (s_last !== 1'b0) begin errors++; $display("FAIL pair_last: got %b want 0", s_last); end
    step(1, 0, 32'h0, 1, 0);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL pair_count: got %0d want 1", obs_q.size()); end
    checks++; if (pack_empty !== 1'b1) begin errors++; $display("FAIL pair_empty: got %b want 1", pack_empty); end
  endtask

  task automatic test_odd_flush();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    do_reset();
    step(1, 1, a, 1, 0);
    step(1, 1, b, 1, 0);
    step(1, 1, c, 0, 0);
    step(1, 0, 32'h0, 1, 0);
    step(1, 0, 32'h0, 1, 0);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL odd_count: got %0d want 2", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== {1'b0, b, a}) begin errors++; $display("FAIL odd_word0: got %h want %h", obs_q[0], {1'b0, b, a}); end
      checks++; if (obs_q[1] !== {1'b1, PAD, c}) begin errors++; $display("FAIL odd_word1: got %h want %h", obs_q[1], {1'b1, PAD, c}); end
    end
    checks++; if (pack_empty !== 1'b1) begin errors++; $display("FAIL odd_empty: got %b want 1", pack_empty); end
  endtask

  task automatic test_backpressure();
    logic [31:0] h [10];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      h[i] = $urandom;
      step(1, 1, h[i], 1, 1);
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bp_held: got %0d writes want 0", obs_q.size()); end
    checks++; if (pack_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b want 1", pack_ovf); end
    checks++; if (pack_empty !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", pack_empty); end
    for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 0);
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL bp_drain_count: got %0d want 4", obs_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_q[k] !== {1'b0, h[2*k+1], h[2*k]}) begin
          errors++; $display("FAIL bp_word%0d: got %h want %h", k, obs_q[k], {1'b0, h[2*k+1], h[2*k]});
        end
      end
    end
    checks++; if (pack_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b want 1", pack_ovf); end
  endtask

  task automatic test_full_pop();
    logic [31:0] h [10];
    do_reset();
    for (int i = 0; i < 10; i++) h[i] = $urandom;
    for (int i = 0; i < 9; i++) step(1, 1, h[i], 1, 1);
    step(1, 1, h[9], 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 0);
    checks++; if (pack_ovf !== 1'b0) begin errors++; $display("FAIL fp_ovf: got %b want 0", pack_ovf); end
    checks++;
    if (obs_q.size() != 5) begin
      errors++; $display("FAIL fp_count: got %0d want 5", obs_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (obs_q[k] !== {1'b0, h[2*k+1], h[2*k]}) begin
          errors++; $display("FAIL fp_word%0d: got %h want %h", k, obs_q[k], {1'b0, h[2*k+1], h[2*k]});
        end
      end
    end
    checks++; if (pack_empty !== 1'b1) begin errors++; $display("FAIL fp_empty: got %b want 1", pack_empty); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    do_reset();
    step(1, 1, 32'hBAD0_BAD0, 1, 0);
    do_reset();
    step(1, 1, x, 1, 0);
    step(1, 1, y, 1, 0);
    step(1, 0, 32'h0, 1, 0);
    step(1, 0, 32'h0, 1, 0);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL rm_count: got %0d want 1", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== {1'b0, y, x}) begin errors++; $display("FAIL rm_word: got %h want %h", obs_q[0], {1'b0, y, x}); end
    end
    checks++;
    if (hash_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL rm_cnt: got %0d want %0d", hash_cnt, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_ce_gating();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    do_reset();
    step(1, 1, a, 1, 1);
    step(1, 1, b, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, $urandom, 0, 0);
      checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL ce_wr_low%0d: got %b want 0", i, s_wr); end
    end
    checks++; if (pack_empty !== 1'b0) begin errors++; $display("FAIL ce_empty: got %b want 0", pack_empty); end
    step(1, 0, 32'h0, 1, 0);
    checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL ce_wr_resume: got %b want 1", s_wr); end
    checks++; if (s_fo !== {b, a}) begin errors++; $display("FAIL ce_fo: got %h want %h", s_fo, {b, a}); end
    step(1, 0, 32'h0, 1, 0);
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL ce_single_word: got %b want 0", s_wr); end
    checks++; if (hash_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL ce_cnt: got %0d want %0d", hash_cnt, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_random();
    bit c, d, e, f;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 7) != 0);
      d = $urandom_range(0, 1);
      e = ($urandom_range(0, 5) != 0);
      f = ($urandom_range(0, 9) < 4);
      step(c, d, $urandom, e, f);
      checks++;
      if (s_wr !== s_mpop) begin errors++; $display("FAIL rnd_wr cycle %0d: got %b want %b", i, s_wr, s_mpop); end
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 32'h0, 1, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < obs_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rnd_word%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
    end
    checks++; if (pack_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf: got %b want %b", pack_ovf, m_ovf); end
    checks++; if (hash_cnt !== exp_cnt()) begin errors++; $display("FAIL rnd_cnt: got %h want %h", hash_cnt, exp_cnt()); end
    checks++;
    if (pack_empty !== (mq.size() == 0 && !m_half_v)) begin
      errors++; $display("FAIL rnd_empty: got %b want %b", pack_empty, (mq.size() == 0 && !m_half_v));
    end
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b0; hash_done = 1'b0; hash_out = '0; m_endn = 1'b1; fo_full = 1'b0;
    model_clear();
    #12;
    test_reset();
    test_pair();
    test_odd_flush();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_ce_gating();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
